// File: rtl/vblank_mem_arbiter.sv
// Grid-RAM arbiter: renderer owns the port in active video, game logic only in vblank.
// Also emits the game step_tick; optional `ARB_SPEED_PORT_EN adds a runtime speed input.
module vblank_mem_arbiter #(
    parameter int BIT             = 10,
    parameter int HRES            = 640,
    parameter int VRES            = 480,
    parameter int H_TOTAL         = 800,
    parameter int V_TOTAL         = 525,
    parameter int ADDR_W          = 8,
    parameter int DATA_W          = 2,
    parameter int FRAMES_PER_STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [BIT-1:0]    x_pos,
    input  logic [BIT-1:0]    y_pos,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_gnt,
    output logic              g_rvalid,
    output logic [DATA_W-1:0] g_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
`ifdef ARB_SPEED_PORT_EN
    input  logic [7:0]        speed,
`endif
    output logic              step_tick
);

`ifdef ARB_SPEED_PORT_EN
    localparam int CNT_W = 8;
`else
    localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
`endif

    typedef enum logic [1:0] {RENDER, STEP, WINDOW} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_frame_cnt;
    logic              r_step_tick;
    logic              r_rvalid;
    logic [CNT_W-1:0]  w_limit;
    logic              w_pre_entry;
    logic              w_exit;
    logic              w_active;
    logic              w_window_open;
    logic              w_gnt;

`ifdef ARB_SPEED_PORT_EN
    logic [7:0] r_speed;
    logic       r_speed_loaded;
    assign w_limit = r_speed;
`else
    assign w_limit = CNT_W'(FRAMES_PER_STEP - 1);
`endif

    // Decode the pixel before (0,VRES) so STEP occupies exactly the vblank-entry cycle.
    assign w_pre_entry = (x_pos == BIT'(H_TOTAL - 1)) && (y_pos == BIT'(VRES - 1));
    assign w_exit      = (x_pos == BIT'(H_TOTAL - 3)) && (y_pos == BIT'(V_TOTAL - 1));
    assign w_active    = (x_pos < BIT'(HRES)) && (y_pos < BIT'(VRES));

    // Grants are also blocked while reset is held and on any active pixel after a timing jump.
    assign w_window_open = ((r_state == STEP) || (r_state == WINDOW)) && !reset && !w_active;
    assign w_gnt         = g_req && w_window_open;

    assign g_gnt     = w_gnt;
    assign mem_addr  = w_gnt ? g_addr : r_addr;
    assign mem_we    = w_gnt && g_we;
    assign mem_wdata = w_gnt ? g_wdata : '0;
    assign r_data    = mem_rdata;
    assign g_rvalid  = r_rvalid;
    assign g_rdata   = r_rvalid ? mem_rdata : '0;
    assign step_tick = r_step_tick;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RENDER;
            r_frame_cnt <= '0;
            r_step_tick <= 1'b0;
            r_rvalid    <= 1'b0;
`ifdef ARB_SPEED_PORT_EN
            r_speed        <= 8'd0;
            r_speed_loaded <= 1'b0;
`endif
        end else begin
            r_rvalid    <= w_gnt && !g_we;
            r_step_tick <= 1'b0;
            case (r_state)
                RENDER: if (w_pre_entry) r_state <= STEP;
                STEP: begin
                    r_state <= WINDOW;
                    if (r_frame_cnt == w_limit) begin
                        r_step_tick <= 1'b1;
                        r_frame_cnt <= '0;
`ifdef ARB_SPEED_PORT_EN
                        r_speed     <= speed;
`endif
                    end else begin
                        r_frame_cnt <= r_frame_cnt + 1'b1;
                    end
                end
                WINDOW: if (w_exit) r_state <= RENDER;
                default: r_state <= RENDER;
            endcase
`ifdef ARB_SPEED_PORT_EN
            if (!r_speed_loaded) begin
                r_speed_loaded <= 1'b1;
                r_speed        <= speed;
            end
`endif
        end
    end

endmodule

// File: tb/tb_vblank_mem_arbiter.sv
// Self-checking bench for vblank_mem_arbiter on a shrunken raster, with a RAM model,
// a per-cycle reference model and a read-data scoreboard.
module tb_vblank_mem_arbiter;

    localparam int BIT     = 10;
    localparam int HRES    = 12;
    localparam int VRES    = 6;
    localparam int H_TOTAL = 16;
    localparam int V_TOTAL = 9;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 2;
    localparam int FPS     = 3;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam int WIN_LEN = (V_TOTAL - VRES) * H_TOTAL - 2;

    logic              clk;
    logic              reset;
    logic [BIT-1:0]    x_pos, y_pos;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              g_req, g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_gnt, g_rvalid;
    logic [DATA_W-1:0] g_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              step_tick;
`ifdef ARB_SPEED_PORT_EN
    logic [7:0]        speed;
`endif

    vblank_mem_arbiter #(
        .BIT(BIT), .HRES(HRES), .VRES(VRES), .H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAMES_PER_STEP(FPS)
    ) dut (
        .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos),
        .r_addr(r_addr), .r_data(r_data),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
        .g_gnt(g_gnt), .g_rvalid(g_rvalid), .g_rdata(g_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ARB_SPEED_PORT_EN
        .speed(speed),
`endif
        .step_tick(step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram    [256];
    logic [DATA_W-1:0] shadow [256];
    logic [DATA_W-1:0] sb_q [$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_ticks = 0;
    int n_gnt   = 0;
    int m_frames = 0;
    int m_speed  = 0;
    bit m_loaded = 1'b0;
    bit m_carry  = 1'b0;
    bit m_tick_q = 1'b0;
    bit m_rv_q   = 1'b0;
    logic [ADDR_W-1:0] s_addr;
    logic              s_we;
    logic [DATA_W-1:0] s_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at x=%0d y=%0d", tag, obs, exp, x_pos, y_pos);
        end
    endtask

    // Compare every output against the reference model, then step the model.
    task automatic sample_check();
        bit entry, exitp, open, gnt;
        int limit;
        @(negedge clk);
        entry = (x_pos == 0) && (y_pos == VRES);
        exitp = (x_pos == H_TOTAL - 3) && (y_pos == V_TOTAL - 1);
        open  = !reset && (m_carry || entry);
        gnt   = g_req && open;
        check("gnt", g_gnt, gnt);
        check("mem_we", mem_we, gnt && g_we);
        check("mem_addr", mem_addr, gnt ? g_addr : r_addr);
        check("mem_wdata", mem_wdata, gnt ? g_wdata : 0);
        check("step_tick", step_tick, m_tick_q);
        check("g_rvalid", g_rvalid, m_rv_q);
        check("r_data", r_data, mem_rdata);
        if (g_rvalid === 1'b1) begin
            if (sb_q.size() == 0) check("rvalid_without_read", g_rvalid, 0);
            else                  check("g_rdata", g_rdata, sb_q.pop_front());
        end else begin
            check("g_rdata_idle", g_rdata, 0);
        end
        if (step_tick === 1'b1) n_ticks++;
        if (g_gnt === 1'b1) n_gnt++;
        s_addr  = mem_addr;
        s_we    = mem_we;
        s_wdata = mem_wdata;
        if (gnt && g_we)  shadow[g_addr] = g_wdata;
        if (gnt && !g_we) sb_q.push_back(shadow[g_addr]);
`ifdef ARB_SPEED_PORT_EN
        limit = m_speed;
`else
        limit = FPS - 1;
`endif
        m_tick_q = 1'b0;
        if (reset) begin
            m_frames = 0;
            m_carry  = 1'b0;
            m_loaded = 1'b0;
            m_speed  = 0;
        end else begin
            if (entry && open) begin
                if (m_frames == limit) begin
                    m_tick_q = 1'b1;
                    m_frames = 0;
`ifdef ARB_SPEED_PORT_EN
                    m_speed  = speed;
`endif
                end else begin
                    m_frames++;
                end
            end
            if (!m_loaded) begin
                m_loaded = 1'b1;
`ifdef ARB_SPEED_PORT_EN
                m_speed  = speed;
`endif
            end
            m_carry = open && !exitp;
        end
        m_rv_q = gnt && !g_we;
    endtask

    // Clock edge: the RAM model and the raster counter advance with blocking drives.
    task automatic advance();
        @(posedge clk);
        #1;
        mem_rdata = ram[s_addr];
        if (s_we) ram[s_addr] = s_wdata;
        if (x_pos == BIT'(H_TOTAL - 1)) begin
            x_pos = '0;
            y_pos = (y_pos == BIT'(V_TOTAL - 1)) ? '0 : y_pos + 1'b1;
        end else begin
            x_pos = x_pos + 1'b1;
        end
    endtask

    task automatic cyc();
        sample_check();
        advance();
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic run_until(input int x, input int y);
        for (int k = 0; !(x_pos == BIT'(x) && y_pos == BIT'(y)); k++) begin
            if (k > 2 * FRAME) begin
                n_tests++;
                n_fail++;
                $error("FAIL run_until: position %0d,%0d not reached", x, y);
                break;
            end
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int run_len, max_run;
        reset = 1'b1; x_pos = '0; y_pos = '0; r_addr = '0;
        g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0; mem_rdata = '0;
        s_addr = '0; s_we = 1'b0; s_wdata = '0;
`ifdef ARB_SPEED_PORT_EN
        speed = 8'(FPS - 1);
`endif
        for (int i = 0; i < 256; i++) begin
            ram[i]    = DATA_W'(i);
            shadow[i] = DATA_W'(i);
        end

        // Reset state
        run_cycles(3);
        reset = 1'b0;
        sample_check();
        check("rst_step_tick", step_tick, 0);
        check("rst_g_rvalid", g_rvalid, 0);
        check("rst_mem_we", mem_we, 0);
        advance();

        // First tick exactly at the FPS-th vblank entry
        n_ticks = 0;
        run_cycles((FPS - 1) * FRAME);
        check("no_tick_early_frames", n_ticks, 0);
        run_until(1, VRES);
        sample_check();
        check("tick_after_entry", step_tick, 1);
        advance();
        run_until(4, 0);
        check("ticks_first_frames", n_ticks, 1);

        // Write request held from active video stalls until vblank entry
        run_until(0, 2);
        g_req = 1'b1; g_we = 1'b1; g_addr = 8'h12; g_wdata = 2'd2; r_addr = 8'h33;
        n_gnt = 0;
        run_until(0, VRES);
        check("no_gnt_active_video", n_gnt, 0);
        sample_check();
        check("wr_gnt", g_gnt, 1);
        check("wr_addr", mem_addr, 8'h12);
        check("wr_we", mem_we, 1);
        check("wr_wdata", mem_wdata, 2);
        advance();
        g_req = 1'b0; g_we = 1'b0;

        // Read back inside vblank; r_addr must be ignored on the grant cycle
        run_until(3, VRES + 1);
        g_req = 1'b1; g_addr = 8'h12; r_addr = 8'h55;
        sample_check();
        check("rd_gnt", g_gnt, 1);
        check("rd_addr", mem_addr, 8'h12);
        advance();
        g_req = 1'b0;
        sample_check();
        check("rd_valid", g_rvalid, 1);
        check("rd_data", g_rdata, 2);
        advance();

        // Continuous read requests for one whole frame
        run_until(0, 0);
        g_req = 1'b1; g_we = 1'b0;
        run_len = 0; max_run = 0;
        for (int i = 0; i < FRAME; i++) begin
            g_addr = ADDR_W'($urandom);
            r_addr = ADDR_W'($urandom);
            sample_check();
            if (g_gnt === 1'b1) begin
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (y_pos == BIT'(V_TOTAL - 1) && x_pos == BIT'(H_TOTAL - 3))
                check("last_window_gnt", g_gnt, 1);
            if (y_pos == BIT'(V_TOTAL - 1) && x_pos >= BIT'(H_TOTAL - 2)) begin
                check("guard_no_gnt", g_gnt, 0);
                check("guard_raddr", mem_addr, r_addr);
            end
            advance();
        end
        check("window_length", max_run, WIN_LEN);

        // Reset mid-window right after a granted read
        run_until(4, VRES + 1);
        g_addr = 8'h12;
        sample_check();
        check("pre_rst_gnt", g_gnt, 1);
        advance();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        sample_check();
        check("post_rst_rvalid", g_rvalid, 0);
        check("post_rst_gnt", g_gnt, 0);
        advance();
        n_gnt = 0;
        run_until(0, VRES);
        check("no_gnt_until_entry", n_gnt, 0);
        n_ticks = 0;
        run_cycles((FPS - 1) * FRAME);
        check("counter_restart_no_tick", n_ticks, 0);
        run_cycles(2);
        check("counter_restart_tick", n_ticks, 1);
        g_req = 1'b0;

`ifdef ARB_SPEED_PORT_EN
        // Speed change takes effect only after the next tick
        speed = 8'd0;
        run_cycles(FPS * FRAME);
        n_ticks = 0;
        run_cycles(3 * FRAME);
        check("speed0_ticks", n_ticks, 3);
        speed = 8'd3;
        n_ticks = 0;
        run_cycles(FRAME);
        check("speed_switch_tick", n_ticks, 1);
        n_ticks = 0;
        run_cycles(4 * FRAME);
        check("speed3_ticks", n_ticks, 1);
`endif

        run_cycles(4);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
